xgmii_rx_engine: RTL and testbench

- Receive-side counterpart of the XGMII TLP-over-UDP transmitter.
- Parses 64-bit XGMII frames carrying PCIe TLPs in IPv4/UDP with a magic word.
- Filters on destination MAC, IP, UDP port and magic word; checks FCS.
- Writes TLP payload words into the PCIe-side FIFO in the shared 72-bit tagged format.

---
 rtl/xgmii_rx_engine_pkg.sv | 50 +++++
 rtl/crc32_d64.sv | 39 +++
 rtl/xgmii_rx_engine.sv | 193 +++++++++++++++++++
 tb/tb_xgmii_rx_engine.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_rx_engine_pkg.sv
// Shared constants and types for the XGMII TLP-over-UDP receive engine:
// FSM encoding, XGMII control patterns, FIFO word layout and filter defaults.
package xgmii_rx_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_e;

  // Bit positions inside the 72-bit tagged FIFO word
  localparam int FIFO_START = 64;
  localparam int FIFO_LAST  = 65;
  localparam int FIFO_EN_LO = 66;
  localparam int FIFO_EN_HI = 67;
  localparam int FIFO_IFG   = 68;
  localparam int FIFO_ERR   = 69;

  localparam logic [7:0]  START_CTRL    = 8'h01;
  localparam logic [63:0] PREAMBLE_WORD = 64'hd5555555555555fb;
  localparam logic [7:0]  TERM_CTRL     = 8'hf0;
  localparam logic [31:0] TERM_HI       = 32'h070707fd;
  localparam logic [7:0]  IDLE_CTRL     = 8'hff;

  localparam logic [2:0]  HDR_LAST_IDX  = 3'd5;

  localparam logic [15:0] DEFAULT_UDP_PORT   = 16'h0d5e;
  localparam logic [31:0] DEFAULT_MAGIC_CODE = 32'h544c_5055;

  localparam logic [31:0] CRC_POLY = 32'hedb88320;
  localparam logic [31:0] CRC_INIT = 32'hffffffff;

  function automatic logic [71:0] fifo_word(input logic [63:0] data,
                                            input logic        start,
                                            input logic        last,
                                            input logic        err);
    logic [71:0] w;
    w             = '0;
    w[63:0]       = data;
    w[FIFO_START] = start;
    w[FIFO_LAST]  = last;
    w[FIFO_EN_LO] = 1'b1;
    w[FIFO_EN_HI] = 1'b1;
    w[FIFO_IFG]   = 1'b0;
    w[FIFO_ERR]   = err;
    return w;
  endfunction

endpackage

// File: rtl/crc32_d64.sv
// Ethernet CRC-32 over 64 bits per clock, lane 0 first, LSB first within a
// byte (reflected form). crc_o holds the raw register; the FCS is its inverse.
module crc32_d64
  import xgmii_rx_engine_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [63:0] data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // NOTE: blocking assignments here on purpose -- each loop step consumes the
  // previous step's value within the same evaluation, and the default first
  // line keeps crc_d fully assigned so no latch is inferred.
  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < 64; i++) begin
      crc_d = {1'b0, crc_d[31:1]} ^ ((crc_d[0] ^ data_i[i]) ? CRC_POLY : 32'h0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else if (init_i) begin
      crc_q <= CRC_INIT;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/xgmii_rx_engine.sv
// XGMII receive engine: filters IPv4/UDP frames carrying TLPs, checks the FCS
// and pushes payload words into the PCIe-side FIFO in 72-bit tagged form.
module xgmii_rx_engine
  import xgmii_rx_engine_pkg::*;
#(
  parameter logic [15:0] UDP_PORT       = DEFAULT_UDP_PORT,
  parameter logic [31:0] MAGIC_CODE     = DEFAULT_MAGIC_CODE,
  parameter int          MAX_DATA_WORDS = 64
) (
  input  logic        xgmii_clk,
  input  logic        sys_rst_n,
  input  logic [71:0] xgmii_rxd,
  input  logic [31:0] if_v4addr,
  input  logic [47:0] if_macaddr,
  output logic [71:0] din,
  output logic        wr_en,
  input  logic        almost_full,
  input  logic        full,
  output logic [15:0] rx_ok_cnt,
  output logic [15:0] rx_crc_err_cnt,
  output logic [15:0] rx_drop_cnt,
  output logic        ovf_err
);

  localparam int WCNT_W = $clog2(MAX_DATA_WORDS + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_DATA_WORDS);

  rx_state_e         state_q;
  logic [2:0]        hdr_idx_q;
  logic [WCNT_W-1:0] word_cnt_q;
  logic [63:0]       hold_q;
  logic              hold_vld_q;
  logic              hold_first_q;
  logic [71:0]       din_q;
  logic              wr_en_q;
  logic [15:0]       ok_cnt_q;
  logic [15:0]       crc_err_cnt_q;
  logic [15:0]       drop_cnt_q;
  logic              ovf_err_q;

  logic [7:0]  rxc;
  logic [63:0] rxd;
  logic [31:0] crc_val;
  logic        is_start;
  logic        is_term;
  logic        crc_ok;
  logic        hdr_ok;

  assign rxc      = xgmii_rxd[71:64];
  assign rxd      = xgmii_rxd[63:0];
  assign is_start = (rxc == START_CTRL) && (rxd == PREAMBLE_WORD);
  assign is_term  = (rxc == TERM_CTRL) && (rxd[63:32] == TERM_HI);
  assign crc_ok   = (rxd[31:0] == ~crc_val);

  crc32_d64 u_crc (
    .clk    (xgmii_clk),
    .rst_n  (sys_rst_n),
    .init_i ((state_q == ST_IDLE) && is_start),
    .en_i   (((state_q == ST_HDR) || (state_q == ST_DATA)) && (rxc == 8'h00)),
    .data_i (rxd),
    .crc_o  (crc_val)
  );

  // Header words carry the Ethernet/IPv4/UDP bytes in wire order, lane 0 first
  always_comb begin
    hdr_ok = 1'b1;
    case (hdr_idx_q)
      3'd0: begin
        for (int i = 0; i < 6; i++) begin
          if (rxd[8*i +: 8] != if_macaddr[8*(5-i) +: 8]) hdr_ok = 1'b0;
        end
      end
      3'd1: hdr_ok = (rxd[39:32] == 8'h08) && (rxd[47:40] == 8'h00) &&
                     (rxd[55:48] == 8'h45);
      3'd2: hdr_ok = (rxd[63:56] == 8'h11);
      3'd3: hdr_ok = (rxd[55:48] == if_v4addr[31:24]) &&
                     (rxd[63:56] == if_v4addr[23:16]);
      3'd4: hdr_ok = (rxd[7:0]   == if_v4addr[15:8]) &&
                     (rxd[15:8]  == if_v4addr[7:0]) &&
                     (rxd[39:32] == UDP_PORT[15:8]) &&
                     (rxd[47:40] == UDP_PORT[7:0]);
      3'd5: hdr_ok = (rxd[23:16] == MAGIC_CODE[31:24]) &&
                     (rxd[31:24] == MAGIC_CODE[23:16]) &&
                     (rxd[39:32] == MAGIC_CODE[15:8]) &&
                     (rxd[47:40] == MAGIC_CODE[7:0]);
      default: hdr_ok = 1'b0;
    endcase
  end

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      hdr_idx_q     <= '0;
      word_cnt_q    <= '0;
      hold_q        <= '0;
      hold_vld_q    <= 1'b0;
      hold_first_q  <= 1'b0;
      din_q         <= '0;
      wr_en_q       <= 1'b0;
      ok_cnt_q      <= '0;
      crc_err_cnt_q <= '0;
      drop_cnt_q    <= '0;
      ovf_err_q     <= 1'b0;
    end else begin
      // NOTE: the default here makes wr_en a single-cycle pulse; only the
      // branches that write a word raise it again.
      wr_en_q <= 1'b0;
      if (wr_en_q && full) ovf_err_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (is_start) begin
            state_q   <= ST_HDR;
            hdr_idx_q <= '0;
          end
        end

        ST_HDR: begin
          if ((rxc != 8'h00) || !hdr_ok) begin
            state_q    <= ST_DROP;
            drop_cnt_q <= drop_cnt_q + 16'd1;
          end else if (hdr_idx_q == HDR_LAST_IDX) begin
            if (almost_full) begin
              state_q    <= ST_DROP;
              drop_cnt_q <= drop_cnt_q + 16'd1;
            end else begin
              state_q    <= ST_DATA;
              word_cnt_q <= '0;
              hold_vld_q <= 1'b0;
            end
          end else begin
            hdr_idx_q <= hdr_idx_q + 3'd1;
          end
        end

        ST_DATA: begin
          if (rxc == 8'h00) begin
            if (word_cnt_q == WCNT_MAX) begin
              wr_en_q    <= 1'b1;
              din_q      <= fifo_word(hold_q, hold_first_q, 1'b1, 1'b1);
              hold_vld_q <= 1'b0;
              drop_cnt_q <= drop_cnt_q + 16'd1;
              state_q    <= ST_DROP;
            end else begin
              if (hold_vld_q) begin
                wr_en_q <= 1'b1;
                din_q   <= fifo_word(hold_q, hold_first_q, 1'b0, 1'b0);
              end
              hold_q       <= rxd;
              hold_vld_q   <= 1'b1;
              hold_first_q <= (word_cnt_q == '0);
              word_cnt_q   <= word_cnt_q + WCNT_W'(1);
            end
          end else if (is_term) begin
            if (hold_vld_q) begin
              wr_en_q <= 1'b1;
              din_q   <= fifo_word(hold_q, hold_first_q, 1'b1, !crc_ok);
              if (crc_ok) ok_cnt_q      <= ok_cnt_q + 16'd1;
              else        crc_err_cnt_q <= crc_err_cnt_q + 16'd1;
            end else begin
              drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            hold_vld_q <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            // Unexpected control mid-payload: close the packet as errored
            if (hold_vld_q) begin
              wr_en_q <= 1'b1;
              din_q   <= fifo_word(hold_q, hold_first_q, 1'b1, 1'b1);
            end
            hold_vld_q <= 1'b0;
            drop_cnt_q <= drop_cnt_q + 16'd1;
            state_q    <= ST_DROP;
          end
        end

        ST_DROP: begin
          if (rxc == IDLE_CTRL) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign din            = din_q;
  assign wr_en          = wr_en_q;
  assign rx_ok_cnt      = ok_cnt_q;
  assign rx_crc_err_cnt = crc_err_cnt_q;
  assign rx_drop_cnt    = drop_cnt_q;
  assign ovf_err        = ovf_err_q;

endmodule

// File: tb/tb_xgmii_rx_engine.sv
// Scoreboard bench for xgmii_rx_engine: frames are built byte-wise with an
// independent CRC, expected FIFO words are queued and matched on every wr_en.
module tb_xgmii_rx_engine;

  localparam logic [15:0] TB_PORT  = 16'h0d5e;
  localparam logic [31:0] TB_MAGIC = 32'hc0de5eed;
  localparam int          MAXW     = 64;
  localparam logic [47:0] TB_MAC   = 48'h02_1a_2b_3c_4d_5e;
  localparam logic [31:0] TB_IP    = 32'hc0a8_010a;
  localparam logic [71:0] IDLE_W   = {8'hff, 64'h0707070707070707};

  logic        xgmii_clk = 1'b0;
  logic        sys_rst_n;
  logic [71:0] xgmii_rxd;
  logic [31:0] if_v4addr;
  logic [47:0] if_macaddr;
  logic [71:0] din;
  logic        wr_en;
  logic        almost_full;
  logic        full;
  logic [15:0] rx_ok_cnt;
  logic [15:0] rx_crc_err_cnt;
  logic [15:0] rx_drop_cnt;
  logic        ovf_err;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_ok = 0, exp_crc = 0, exp_drop = 0;

  logic [71:0] exp_q[$];
  logic [71:0] frame_q[$];
  logic [63:0] pay_q[$];

  always #5 xgmii_clk = ~xgmii_clk;

  xgmii_rx_engine #(
    .UDP_PORT       (TB_PORT),
    .MAGIC_CODE     (TB_MAGIC),
    .MAX_DATA_WORDS (MAXW)
  ) dut (
    .xgmii_clk      (xgmii_clk),
    .sys_rst_n      (sys_rst_n),
    .xgmii_rxd      (xgmii_rxd),
    .if_v4addr      (if_v4addr),
    .if_macaddr     (if_macaddr),
    .din            (din),
    .wr_en          (wr_en),
    .almost_full    (almost_full),
    .full           (full),
    .rx_ok_cnt      (rx_ok_cnt),
    .rx_crc_err_cnt (rx_crc_err_cnt),
    .rx_drop_cnt    (rx_drop_cnt),
    .ovf_err        (ovf_err)
  );

  // Every FIFO write is matched against the head of the expected queue
  initial begin
    logic [71:0] e;
    forever begin
      @(negedge xgmii_clk);
      if (wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write din=%h expected no write", din);
        end else begin
          e = exp_q.pop_front();
          if (din !== e) begin
            errors++;
            $display("FAIL fifo_word din=%h expected=%h", din, e);
          end
        end
      end
    end
  end

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    for (int k = 0; k < 8; k++) begin
      if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hedb88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [71:0] tb_word(input logic [63:0] d, input bit s, input bit l, input bit er);
    return {2'b00, er, 1'b0, 2'b11, l, s, d};
  endfunction

  // corrupt: 0 none, 1 one destination MAC byte wrong, 2 magic word zero
  task automatic build_frame(input int n, input bit bad_fcs, input int corrupt);
    logic [7:0]  hdr[48];
    logic [47:0] mac;
    logic [31:0] ip, magic, crc, fcs;
    logic [15:0] port;
    logic [63:0] w;
    mac   = TB_MAC;
    ip    = TB_IP;
    port  = TB_PORT;
    magic = (corrupt == 2) ? 32'h0 : TB_MAGIC;
    for (int i = 0; i < 48; i++) hdr[i] = 8'h00;
    for (int i = 0; i < 6; i++) hdr[i] = mac[8*(5-i) +: 8];
    hdr[6] = 8'h02; hdr[11] = 8'h01;
    hdr[12] = 8'h08; hdr[13] = 8'h00; hdr[14] = 8'h45;
    hdr[16] = 8'h00; hdr[17] = 8'h5c; hdr[18] = 8'h12; hdr[19] = 8'h34;
    hdr[20] = 8'h40; hdr[22] = 8'h40; hdr[23] = 8'h11;
    hdr[24] = 8'hbe; hdr[25] = 8'hef;
    hdr[26] = 8'hc0; hdr[27] = 8'ha8; hdr[28] = 8'h01; hdr[29] = 8'h01;
    for (int i = 0; i < 4; i++) hdr[30+i] = ip[8*(3-i) +: 8];
    hdr[34] = 8'h0d; hdr[35] = 8'h5e;
    hdr[36] = port[15:8]; hdr[37] = port[7:0];
    hdr[38] = 8'h00; hdr[39] = 8'h48;
    for (int i = 0; i < 4; i++) hdr[42+i] = magic[8*(3-i) +: 8];
    if (corrupt == 1) hdr[3] = hdr[3] ^ 8'h01;

    frame_q.delete();
    pay_q.delete();
    frame_q.push_back({8'h01, 64'hd5555555555555fb});
    crc = 32'hffffffff;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) begin
        w[8*i +: 8] = hdr[8*k+i];
        crc = crc_byte(crc, hdr[8*k+i]);
      end
      frame_q.push_back({8'h00, w});
    end
    for (int p = 0; p < n; p++) begin
      w = {$urandom, $urandom};
      pay_q.push_back(w);
      for (int i = 0; i < 8; i++) crc = crc_byte(crc, w[8*i +: 8]);
      frame_q.push_back({8'h00, w});
    end
    fcs = ~crc;
    if (bad_fcs) fcs[0] = ~fcs[0];
    frame_q.push_back({8'hf0, 32'h070707fd, fcs});
  endtask

  task automatic send_frame(input int n, input bit bad_fcs, input int corrupt,
                            input bit af, input bit idle_after);
    build_frame(n, bad_fcs, corrupt);
    if (corrupt != 0 || af || n == 0) begin
      exp_drop++;
    end else if (n > MAXW) begin
      for (int i = 0; i < MAXW; i++)
        exp_q.push_back(tb_word(pay_q[i], i == 0, i == MAXW-1, i == MAXW-1));
      exp_drop++;
    end else begin
      for (int i = 0; i < n; i++)
        exp_q.push_back(tb_word(pay_q[i], i == 0, i == n-1, (i == n-1) && bad_fcs));
      if (bad_fcs) exp_crc++;
      else         exp_ok++;
    end
    almost_full = af;
    foreach (frame_q[i]) begin
      @(negedge xgmii_clk);
      xgmii_rxd = frame_q[i];
    end
    @(negedge xgmii_clk);
    almost_full = 1'b0;
    xgmii_rxd   = IDLE_W;
    if (idle_after) repeat (4) @(negedge xgmii_clk);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({din, wr_en, ovf_err} !== 74'h0) begin
      errors++;
      $display("FAIL reset_outputs din=%h wr_en=%b ovf=%b expected all zero", din, wr_en, ovf_err);
    end
    repeat (3) @(negedge xgmii_clk);
    sys_rst_n = 1'b1;
    @(negedge xgmii_clk);
    checks++;
    if ({rx_ok_cnt, rx_crc_err_cnt, rx_drop_cnt} !== 48'h0) begin
      errors++;
      $display("FAIL reset_counters ok=%0d crc=%0d drop=%0d expected 0 0 0",
               rx_ok_cnt, rx_crc_err_cnt, rx_drop_cnt);
    end
  endtask

  task automatic test_frames(input string name, input int n, input bit bad_fcs, input int corrupt);
    send_frame(n, bad_fcs, corrupt, 1'b0, 1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes missing=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if ({rx_ok_cnt, rx_crc_err_cnt, rx_drop_cnt} !== {exp_ok, exp_crc, exp_drop}) begin
      errors++;
      $display("FAIL %s_counters ok=%0d crc=%0d drop=%0d expected %0d %0d %0d", name,
               rx_ok_cnt, rx_crc_err_cnt, rx_drop_cnt, exp_ok, exp_crc, exp_drop);
    end
  endtask

  task automatic test_back_to_back;
    full = 1'b1;
    send_frame(2, 1'b0, 0, 1'b0, 1'b0);
    full = 1'b0;
    send_frame(1, 1'b0, 0, 1'b0, 1'b1);
    checks++;
    if (exp_q.size() != 0 || rx_ok_cnt !== exp_ok) begin
      errors++;
      $display("FAIL b2b missing=%0d ok=%0d expected 0 %0d", exp_q.size(), rx_ok_cnt, exp_ok);
      exp_q.delete();
    end
    checks++;
    if (ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky ovf_err=%b expected 1", ovf_err);
    end
  endtask

  task automatic test_almost_full;
    send_frame(3, 1'b0, 0, 1'b1, 1'b1);
    checks++;
    if (exp_q.size() != 0 || rx_drop_cnt !== exp_drop || rx_ok_cnt !== exp_ok) begin
      errors++;
      $display("FAIL almost_full_drop drop=%0d ok=%0d expected %0d %0d",
               rx_drop_cnt, rx_ok_cnt, exp_drop, exp_ok);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_midframe;
    logic [71:0] first_w;
    build_frame(3, 1'b0, 0);
    first_w = tb_word(pay_q[0], 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge xgmii_clk);
      xgmii_rxd = frame_q[i];
    end
    @(posedge xgmii_clk);
    #2;
    checks++;
    if (wr_en !== 1'b1 || din !== first_w) begin
      errors++;
      $display("FAIL midframe_write wr_en=%b din=%h expected 1 %h", wr_en, din, first_w);
    end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, din, ovf_err, rx_ok_cnt, rx_crc_err_cnt, rx_drop_cnt} !== '0) begin
      errors++;
      $display("FAIL midframe_reset wr_en=%b din=%h ovf=%b ok=%0d crc=%0d drop=%0d expected all zero",
               wr_en, din, ovf_err, rx_ok_cnt, rx_crc_err_cnt, rx_drop_cnt);
    end
    @(negedge xgmii_clk);
    xgmii_rxd = IDLE_W;
    sys_rst_n = 1'b1;
    exp_ok = 0; exp_crc = 0; exp_drop = 0;
    repeat (2) @(negedge xgmii_clk);
    test_frames("after_reset", 2, 1'b0, 0);
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    xgmii_rxd   = IDLE_W;
    almost_full = 1'b0;
    full        = 1'b0;
    if_v4addr   = TB_IP;
    if_macaddr  = TB_MAC;

    test_reset;
    test_frames("good3", 3, 1'b0, 0);
    test_frames("badfcs3", 3, 1'b1, 0);
    test_frames("mac_off", 3, 1'b0, 1);
    test_frames("good_after_mac", 2, 1'b0, 0);
    test_frames("magic_zero", 3, 1'b0, 2);
    test_frames("good_after_magic", 4, 1'b0, 0);
    test_frames("one_word", 1, 1'b0, 0);
    test_frames("zero_word", 0, 1'b0, 0);
    test_frames("truncate", MAXW + 2, 1'b0, 0);
    test_frames("max_words", MAXW, 1'b0, 0);
    test_back_to_back;
    test_almost_full;
    test_reset_midframe;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
